// File: rtl/regfile_pkg.sv
// Shared defaults and read-source encoding for the datapath register file.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package regfile_pkg;

    // Default geometry of the general-purpose register file, also used by the bench.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Where a read port takes its next output value from.
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ENTRY  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: priority mux for the read value plus registered data and valid.
// Latency: 1 cycle from the sampling edge to op/op_vld.
// Backpressure: none; a read can be issued every cycle, op holds when not read.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AW       = 3,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             clr,
    input  logic             wr_acc,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [WIDTH-1:0] ent_dat,
    output logic [WIDTH-1:0] op,
    output logic             op_vld
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    rd_src_e          src;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] op_d, op_q;
    logic             vld_d, vld_q;

    // Pick the read value: range/clear/zero-entry force 0, then bypass, then storage.
    always_comb begin
        src = SRC_ENTRY;
        if (({1'b0, rd_addr} >= DEPTH_W) || clr) begin
            src = SRC_ZERO;
        end else if (ZERO_REG && (rd_addr == '0)) begin
            src = SRC_ZERO;
        end else if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
            src = SRC_BYPASS;
        end
        case (src)
            SRC_BYPASS: rd_val = wr_dat;
            SRC_ENTRY:  rd_val = ent_dat;
            default:    rd_val = '0;
        endcase
        op_d  = rd_en ? rd_val : op_q;
        vld_d = rd_en;
    end

    // Output data and valid registers; reset discards any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            vld_q <= vld_d;
        end
    end

    assign op     = op_q;
    assign op_vld = vld_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with synchronous clear and address-range error flag.
// Latency: write visible in storage next edge; reads registered, 1 cycle.
// Backpressure: none; every port accepts an access each cycle.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             w,
    input  logic [AW-1:0]    wp,
    input  logic [WIDTH-1:0] ip,
    input  logic             r1,
    input  logic [AW-1:0]    r1p,
    input  logic             r2,
    input  logic [AW-1:0]    r2p,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             op1_vld,
    output logic             op2_vld,
    output logic             addr_err
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wp_ok, r1_ok, r2_ok;
    logic             wr_acc;
    logic [WIDTH-1:0] ent1, ent2;
    logic             addr_err_d, addr_err_q;

    // Address range checks, write acceptance, storage read taps and error flag.
    always_comb begin
        wp_ok      = ({1'b0, wp}  < DEPTH_W);
        r1_ok      = ({1'b0, r1p} < DEPTH_W);
        r2_ok      = ({1'b0, r2p} < DEPTH_W);
        wr_acc     = w && !clr && wp_ok && !(ZERO_REG && (wp == '0));
        ent1       = r1_ok ? mem_q[r1p] : '0;
        ent2       = r2_ok ? mem_q[r2p] : '0;
        addr_err_d = (w && !wp_ok) || (r1 && !r1_ok) || (r2 && !r2_ok);
    end

    // Next storage contents: clear wins over a concurrent write.
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_acc) begin
            mem_d[wp] = ip;
        end
    end

    // Storage and error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            addr_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

    regfile_rdport #(
        .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd1 (
        .clk(clk), .reset(reset), .rd_en(r1), .rd_addr(r1p), .clr(clr),
        .wr_acc(wr_acc), .wr_addr(wp), .wr_dat(ip), .ent_dat(ent1),
        .op(op1), .op_vld(op1_vld)
    );

    regfile_rdport #(
        .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd2 (
        .clk(clk), .reset(reset), .rd_en(r2), .rd_addr(r2p), .clr(clr),
        .wr_acc(wr_acc), .wr_addr(wp), .wr_dat(ip), .ent_dat(ent2),
        .op(op2), .op_vld(op2_vld)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: four configurations driven from one shared stimulus.
// Latency: expects read data/valid and addr_err one cycle after the sampling edge.
// Backpressure: none.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0, w = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [2:0] wp = '0, r1p = '0, r2p = '0;
    logic [7:0] ip = '0;

    // dut 0: default, 1: no bypass, 2: hardwired zero entry, 3: depth 6
    logic [7:0] op1_0, op2_0, op1_1, op2_1, op1_2, op2_2, op1_3, op2_3;
    logic       v1_0, v2_0, e_0, v1_1, v2_1, e_1, v1_2, v2_2, e_2, v1_3, v2_3, e_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_def (
        .clk(clk), .reset(reset), .clr(clr), .w(w), .wp(wp), .ip(ip),
        .r1(r1), .r1p(r1p), .r2(r2), .r2p(r2p),
        .op1(op1_0), .op2(op2_0), .op1_vld(v1_0), .op2_vld(v2_0), .addr_err(e_0));

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .clr(clr), .w(w), .wp(wp), .ip(ip),
        .r1(r1), .r1p(r1p), .r2(r2), .r2p(r2p),
        .op1(op1_1), .op2(op2_1), .op1_vld(v1_1), .op2_vld(v2_1), .addr_err(e_1));

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_zr (
        .clk(clk), .reset(reset), .clr(clr), .w(w), .wp(wp), .ip(ip),
        .r1(r1), .r1p(r1p), .r2(r2), .r2p(r2p),
        .op1(op1_2), .op2(op2_2), .op1_vld(v1_2), .op2_vld(v2_2), .addr_err(e_2));

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_d6 (
        .clk(clk), .reset(reset), .clr(clr), .w(w), .wp(wp), .ip(ip),
        .r1(r1), .r1p(r1p), .r2(r2), .r2p(r2p),
        .op1(op1_3), .op2(op2_3), .op1_vld(v1_3), .op2_vld(v2_3), .addr_err(e_3));

    typedef struct {
        bit         rst;
        int         dut;
        logic       clr, w;
        logic [2:0] wp;
        logic [7:0] ip;
        logic       r1;
        logic [2:0] r1p;
        logic       r2;
        logic [2:0] r2p;
        logic [7:0] e1, e2;
        logic       ev1, ev2, eerr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input bit rst, input int dut, input logic c, input logic wi,
                       input logic [2:0] wpi, input logic [7:0] ipi,
                       input logic a1, input logic [2:0] p1, input logic a2, input logic [2:0] p2,
                       input logic [7:0] e1, input logic [7:0] e2,
                       input logic ev1, input logic ev2, input logic eerr);
        vec_t v;
        v.rst = rst; v.dut = dut; v.clr = c; v.w = wi; v.wp = wpi; v.ip = ipi;
        v.r1 = a1; v.r1p = p1; v.r2 = a2; v.r2p = p2;
        v.e1 = e1; v.e2 = e2; v.ev1 = ev1; v.ev2 = ev2; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic get_out(input int d, output logic [7:0] a1, output logic [7:0] a2,
                           output logic b1, output logic b2, output logic er);
        case (d)
            1:       begin a1 = op1_1; a2 = op2_1; b1 = v1_1; b2 = v2_1; er = e_1; end
            2:       begin a1 = op1_2; a2 = op2_2; b1 = v1_2; b2 = v2_2; er = e_2; end
            3:       begin a1 = op1_3; a2 = op2_3; b1 = v1_3; b2 = v2_3; er = e_3; end
            default: begin a1 = op1_0; a2 = op2_0; b1 = v1_0; b2 = v2_0; er = e_0; end
        endcase
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        clr = 1'b0; w = 1'b0; r1 = 1'b0; r2 = 1'b0;
        wp = '0; ip = '0; r1p = '0; r2p = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] a1, a2;
        logic       b1, b2, er;
        vec_t       e;

        // Reset state, then every address on both ports (default config)
        for (int i = 0; i < 8; i++)
            add(i == 0, 0, 0, 0, 0, 8'h00, 1, 3'(i), 1, 3'(7 - i), 8'h00, 8'h00, 1, 1, 0);
        // Write then read next cycle; valid is a single-cycle pulse
        add(0, 0, 0, 1, 3'd2, 8'h1E, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 1, 3'd2, 0, 0, 8'h1E, 8'h00, 1, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h1E, 8'h00, 0, 0, 0);
        // Same-edge write+read with bypass
        add(0, 0, 0, 1, 3'd3, 8'h05, 0, 0, 0, 0, 8'h1E, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 3'd3, 8'h28, 1, 3'd3, 1, 3'd3, 8'h28, 8'h28, 1, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 1, 3'd3, 1, 3'd2, 8'h28, 8'h1E, 1, 1, 0);
        // Same-edge write+read without bypass returns old data, new data next cycle
        add(1, 1, 0, 1, 3'd3, 8'h05, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 3'd3, 8'h28, 1, 3'd3, 1, 3'd3, 8'h05, 8'h05, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 3'd3, 0, 0, 8'h28, 8'h05, 1, 0, 0);
        // Hardwired zero entry, including bypass attempt to entry 0
        add(1, 2, 0, 1, 3'd1, 8'h33, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2, 0, 1, 3'd0, 8'h5A, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2, 0, 0, 0, 8'h00, 1, 3'd0, 1, 3'd1, 8'h00, 8'h33, 1, 1, 0);
        add(0, 2, 0, 1, 3'd0, 8'h77, 1, 3'd0, 1, 3'd0, 8'h00, 8'h00, 1, 1, 0);
        // Depth 6: out-of-range write/read flag an error, entries untouched
        for (int i = 0; i < 6; i++)
            add(i == 0, 3, 0, 1, 3'(i), 8'(8'hA0 + i), 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 3, 0, 0, 0, 8'h00, 1, 3'd0, 1, 3'd5, 8'hA0, 8'hA5, 1, 1, 0);
        add(0, 3, 0, 1, 3'd7, 8'hEE, 0, 0, 0, 0, 8'hA0, 8'hA5, 0, 0, 1);
        add(0, 3, 0, 0, 0, 8'h00, 0, 0, 1, 3'd6, 8'hA0, 8'h00, 0, 1, 1);
        add(0, 3, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA0, 8'h00, 0, 0, 0);
        add(0, 3, 0, 1, 3'd6, 8'hBB, 1, 3'd6, 0, 0, 8'h00, 8'h00, 1, 0, 1);
        for (int i = 0; i < 6; i++)
            add(0, 3, 0, 0, 0, 8'h00, 1, 3'(i), 1, 3'(5 - i),
                8'(8'hA0 + i), 8'(8'hA5 - i), 1, 1, 0);
        // Fill with 10..80, then clear with a concurrent write
        for (int i = 0; i < 8; i++)
            add(i == 0, 0, 0, 1, 3'(i), 8'(10 * (i + 1)), 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 1, 3'd4, 1, 3'd7, 8'd50, 8'd80, 1, 1, 0);
        add(0, 0, 1, 1, 3'd4, 8'hFF, 1, 3'd5, 1, 3'd4, 8'h00, 8'h00, 1, 1, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 0, 0, 8'h00, 1, 3'(i), 1, 3'(7 - i), 8'h00, 8'h00, 1, 1, 0);

        // Outputs of every configuration are 0 while reset is held
        #1;
        for (int d = 0; d < 4; d++) begin
            get_out(d, a1, a2, b1, b2, er);
            check($sformatf("rst d%0d op1", d), a1, 8'h00);
            check($sformatf("rst d%0d op2", d), a2, 8'h00);
            check($sformatf("rst d%0d vld", d), {6'd0, b1, b2}, 8'h00);
            check($sformatf("rst d%0d err", d), {7'd0, er}, 8'h00);
        end
        step();
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            clr = vecs[i].clr; w = vecs[i].w; wp = vecs[i].wp; ip = vecs[i].ip;
            r1 = vecs[i].r1; r1p = vecs[i].r1p; r2 = vecs[i].r2; r2p = vecs[i].r2p;
            sb.push_back(vecs[i]);
            step();
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb v%0d: got empty queue expected entry", i);
            end else begin
                e = sb.pop_front();
                get_out(e.dut, a1, a2, b1, b2, er);
                check($sformatf("v%0d d%0d op1", i, e.dut), a1, e.e1);
                check($sformatf("v%0d d%0d op2", i, e.dut), a2, e.e2);
                check($sformatf("v%0d d%0d op1_vld", i, e.dut), {7'd0, b1}, {7'd0, e.ev1});
                check($sformatf("v%0d d%0d op2_vld", i, e.dut), {7'd0, b2}, {7'd0, e.ev2});
                check($sformatf("v%0d d%0d addr_err", i, e.dut), {7'd0, er}, {7'd0, e.eerr});
            end
        end

        // Reset asserted mid-cycle during back-to-back reads clears outputs at once
        idle();
        w = 1'b1; wp = 3'd1; ip = 8'h11;
        step();
        idle();
        r1 = 1'b1; r1p = 3'd1;
        step();
        check("seq op1 read", op1_0, 8'h11);
        check("seq op1_vld read", {7'd0, v1_0}, 8'h01);
        step();
        check("seq op1 b2b", op1_0, 8'h11);
        check("seq op1_vld b2b", {7'd0, v1_0}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("seq op1 async rst", op1_0, 8'h00);
        check("seq op1_vld async rst", {7'd0, v1_0}, 8'h00);
        step();
        check("seq op1 held rst", op1_0, 8'h00);
        check("seq op1_vld held rst", {7'd0, v1_0}, 8'h00);
        reset = 1'b0;
        step();
        check("seq op1 post rst", op1_0, 8'h00);
        check("seq op1_vld post rst", {7'd0, v1_0}, 8'h01);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
